noc_mem_responder: RTL and testbench

NOC_MEM_RESPONDER -- requirements
Module: noc_mem_responder

---
 rtl/noc_mem_responder.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_noc_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mem_responder.sv
// -----------------------------------------------------------------------------
// noc_mem_responder
//
// Memory endpoint sitting on a router's local port. Accepts read/write request
// packets on the request plane, services them against a word-addressed register
// array and returns one response packet per request on the response plane.
//
// Packet format (header flit, request and response):
//   [1:0] dst_x  [3:2] dst_y  [5:4] src_x  [7:6] src_y  [8] op (1=write)
//   [12:9] len-1  [14:13] status (00 OKAY, 10 SLVERR)  [31:15] zero
// Request:  header, word address, then len data beats for writes.
// Response: header; for reads followed by len data beats.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_in_*_i/_o         AXI-Stream slave: request packets from the router
//   resp_out_*_o/_i       AXI-Stream master: response packets to the router
// -----------------------------------------------------------------------------
module noc_mem_responder #(
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 4,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int MEM_DEPTH     = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    req_in_tvalid_i,
    output logic                    req_in_tready_o,
    input  logic [DATA_WIDTH-1:0]   req_in_tdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_in_tstrb_i,
    input  logic                    req_in_tlast_i,
    input  logic [ID_WIDTH-1:0]     req_in_tid_i,

    output logic                    resp_out_tvalid_o,
    input  logic                    resp_out_tready_i,
    output logic [DATA_WIDTH-1:0]   resp_out_tdata_o,
    output logic [DATA_WIDTH/8-1:0] resp_out_tstrb_o,
    output logic                    resp_out_tlast_o,
    output logic [ID_WIDTH-1:0]     resp_out_tid_o
);

    localparam int X_W    = $clog2(MAX_ROUTERS_X);
    localparam int Y_W    = $clog2(MAX_ROUTERS_Y);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // state     | meaning
    // ST_HDR    | waiting for a request header flit
    // ST_ADDR   | waiting for the word-address flit
    // ST_WDATA  | absorbing write data beats into memory
    // ST_DRAIN  | discarding flits up to TLAST after a framing error
    // ST_RESP_HDR | presenting the response header
    // ST_RDATA  | presenting read data beats
    typedef enum logic [2:0] {
        ST_HDR,
        ST_ADDR,
        ST_WDATA,
        ST_DRAIN,
        ST_RESP_HDR,
        ST_RDATA
    } state_e;

    state_e              state_q, state_d;
    logic [X_W-1:0]      src_x_q, src_x_d;
    logic [Y_W-1:0]      src_y_q, src_y_d;
    logic                op_q, op_d;
    logic [3:0]          lenm1_q, lenm1_d;
    logic [ID_WIDTH-1:0] tid_q, tid_d;
    logic [31:0]         addr_q, addr_d;
    logic [4:0]          beat_q, beat_d;
    logic                range_err_q, range_err_d;   // address window overruns memory
    logic                frame_err_q, frame_err_d;   // packet framing was malformed
    logic                hdr_only_q, hdr_only_d;     // request ended on its header flit
    logic                rdy_q;                      // low only until first edge after reset

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    logic                  req_acc;
    logic                  resp_acc;
    logic                  range_err_w;
    logic [32:0]           mem_addr_w;
    logic                  mem_in_range;
    logic [AW-1:0]         mem_idx;
    logic                  last_beat_w;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] resp_hdr;
    logic                  resp_hdr_last;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    assign req_acc  = req_in_tvalid_i & req_in_tready_o;
    assign resp_acc = resp_out_tvalid_o & resp_out_tready_i;

    // 33-bit sums so a large address plus length cannot wrap into range.
    assign range_err_w  = ({1'b0, req_in_tdata_i[31:0]} + 33'(lenm1_q) + 33'd1) > 33'(MEM_DEPTH);
    assign mem_addr_w   = {1'b0, addr_q} + 33'(beat_q);
    assign mem_in_range = mem_addr_w < 33'(MEM_DEPTH);
    assign mem_idx      = mem_addr_w[AW-1:0];
    assign last_beat_w  = (beat_q == {1'b0, lenm1_q});

    assign mem_we  = (state_q == ST_WDATA) && req_acc && !range_err_q && mem_in_range;
    assign rd_data = (range_err_q || !mem_in_range) ? '0 : mem_q[mem_idx];

    assign resp_hdr_last = op_q | hdr_only_q;

    always_comb begin
        resp_hdr        = '0;
        resp_hdr[1:0]   = 2'(src_x_q);
        resp_hdr[3:2]   = 2'(src_y_q);
        resp_hdr[5:4]   = 2'(ROUTER_X);
        resp_hdr[7:6]   = 2'(ROUTER_Y);
        resp_hdr[8]     = op_q;
        resp_hdr[12:9]  = lenm1_q;
        resp_hdr[14:13] = (range_err_q || frame_err_q) ? 2'b10 : 2'b00;
    end

    // ------------------------------------------------------------------------
    // Request-side ready and response-side outputs
    // ------------------------------------------------------------------------
    always_comb begin
        req_in_tready_o = 1'b0;
        if (rdy_q) begin
            req_in_tready_o = (state_q == ST_HDR) || (state_q == ST_ADDR) ||
                              (state_q == ST_WDATA) || (state_q == ST_DRAIN);
        end
    end

    // All response outputs are decoded from registers only, so they hold
    // while the downstream stalls.
    always_comb begin
        resp_out_tvalid_o = 1'b0;
        resp_out_tdata_o  = '0;
        resp_out_tstrb_o  = '0;
        resp_out_tlast_o  = 1'b0;
        resp_out_tid_o    = '0;
        case (state_q)
            ST_RESP_HDR: begin
                resp_out_tvalid_o = 1'b1;
                resp_out_tdata_o  = resp_hdr;
                resp_out_tstrb_o  = {STRB_W{1'b1}};
                resp_out_tlast_o  = resp_hdr_last;
                resp_out_tid_o    = tid_q;
            end
            ST_RDATA: begin
                resp_out_tvalid_o = 1'b1;
                resp_out_tdata_o  = rd_data;
                resp_out_tstrb_o  = {STRB_W{1'b1}};
                resp_out_tlast_o  = last_beat_w;
                resp_out_tid_o    = tid_q;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        src_x_d     = src_x_q;
        src_y_d     = src_y_q;
        op_d        = op_q;
        lenm1_d     = lenm1_q;
        tid_d       = tid_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        range_err_d = range_err_q;
        frame_err_d = frame_err_q;
        hdr_only_d  = hdr_only_q;

        case (state_q)
            ST_HDR: begin
                if (req_acc) begin
                    src_x_d     = req_in_tdata_i[4 +: X_W];
                    src_y_d     = req_in_tdata_i[6 +: Y_W];
                    op_d        = req_in_tdata_i[8];
                    lenm1_d     = req_in_tdata_i[12:9];
                    tid_d       = req_in_tid_i;
                    addr_d      = '0;
                    beat_d      = '0;
                    range_err_d = 1'b0;
                    frame_err_d = req_in_tlast_i;
                    hdr_only_d  = req_in_tlast_i;
                    state_d     = req_in_tlast_i ? ST_RESP_HDR : ST_ADDR;
                end
            end

            ST_ADDR: begin
                if (req_acc) begin
                    addr_d      = req_in_tdata_i[31:0];
                    range_err_d = range_err_w;
                    beat_d      = '0;
                    if (!op_q) begin
                        if (req_in_tlast_i) begin
                            state_d = ST_RESP_HDR;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_DRAIN;
                        end
                    end else begin
                        if (req_in_tlast_i) begin
                            frame_err_d = 1'b1;
                            state_d     = ST_RESP_HDR;
                        end else begin
                            state_d = ST_WDATA;
                        end
                    end
                end
            end

            ST_WDATA: begin
                if (req_acc) begin
                    beat_d = beat_q + 5'd1;
                    if (req_in_tlast_i) begin
                        if (!last_beat_w) begin
                            frame_err_d = 1'b1;
                        end
                        state_d = ST_RESP_HDR;
                    end else if (last_beat_w) begin
                        // Sender overran its declared length.
                        frame_err_d = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (req_acc && req_in_tlast_i) begin
                    state_d = ST_RESP_HDR;
                end
            end

            ST_RESP_HDR: begin
                if (resp_acc) begin
                    beat_d  = '0;
                    state_d = resp_hdr_last ? ST_HDR : ST_RDATA;
                end
            end

            ST_RDATA: begin
                if (resp_acc) begin
                    if (last_beat_w) begin
                        state_d = ST_HDR;
                    end else begin
                        beat_d = beat_q + 5'd1;
                    end
                end
            end

            default: state_d = ST_HDR;
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HDR;
            src_x_q     <= '0;
            src_y_q     <= '0;
            op_q        <= 1'b0;
            lenm1_q     <= '0;
            tid_q       <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            range_err_q <= 1'b0;
            frame_err_q <= 1'b0;
            hdr_only_q  <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_x_q     <= src_x_d;
            src_y_q     <= src_y_d;
            op_q        <= op_d;
            lenm1_q     <= lenm1_d;
            tid_q       <= tid_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            range_err_q <= range_err_d;
            frame_err_q <= frame_err_d;
            hdr_only_q  <= hdr_only_d;
            rdy_q       <= 1'b1;
        end
    end

    // Memory array is deliberately outside reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (req_in_tstrb_i[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= req_in_tdata_i[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_mem_responder.sv
module tb_noc_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rq_tvalid;
    logic        rq_tready;
    logic [31:0] rq_tdata;
    logic [3:0]  rq_tstrb;
    logic        rq_tlast;
    logic [3:0]  rq_tid;
    logic        rs_tvalid;
    logic        rs_tready;
    logic [31:0] rs_tdata;
    logic [3:0]  rs_tstrb;
    logic        rs_tlast;
    logic [3:0]  rs_tid;

    noc_mem_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_in_tvalid_i   (rq_tvalid),
        .req_in_tready_o   (rq_tready),
        .req_in_tdata_i    (rq_tdata),
        .req_in_tstrb_i    (rq_tstrb),
        .req_in_tlast_i    (rq_tlast),
        .req_in_tid_i      (rq_tid),
        .resp_out_tvalid_o (rs_tvalid),
        .resp_out_tready_i (rs_tready),
        .resp_out_tdata_o  (rs_tdata),
        .resp_out_tstrb_o  (rs_tstrb),
        .resp_out_tlast_o  (rs_tlast),
        .resp_out_tid_o    (rs_tid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic [3:0]  tid;
    } flit_t;

    flit_t       exp_q[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    logic        toggle = 1'b0;
    logic [31:0] wd [16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h expected=%h", nm, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] req_hdr(input logic op, input logic [1:0] sx,
                                            input logic [1:0] sy, input logic [3:0] lm1);
        return {17'b0, 2'b00, lm1, op, sy, sx, 2'b00, 2'b00};
    endfunction

    // Response header as seen from router (0,0): dst = requester, src = (0,0).
    function automatic logic [31:0] rsp_hdr(input logic [1:0] dx, input logic [1:0] dy,
                                            input logic op, input logic [3:0] lm1, input logic err);
        return {17'b0, (err ? 2'b10 : 2'b00), lm1, op, 2'b00, 2'b00, dy, dx};
    endfunction

    task automatic expect_flit(input logic [31:0] d, input logic l, input logic [3:0] id);
        flit_t f;
        f.data = d;
        f.last = l;
        f.tid  = id;
        exp_q.push_back(f);
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic        stall_q = 1'b0;
        logic [31:0] s_data  = '0;
        logic        s_last  = 1'b0;
        logic [3:0]  s_tid   = '0;
        flit_t       e;
        forever begin
            @(negedge clk);
            if (rst_n && stall_q) begin
                n_chk++;
                if (!rs_tvalid || rs_tdata !== s_data || rs_tlast !== s_last || rs_tid !== s_tid) begin
                    $display("FAIL stall_hold got v=%b d=%h l=%b id=%h expected v=1 d=%h l=%b id=%h",
                             rs_tvalid, rs_tdata, rs_tlast, rs_tid, s_data, s_last, s_tid);
                end else n_pass++;
            end
            stall_q = 1'b0;
            if (rst_n && rs_tvalid) begin
                if (rs_tready) begin
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL resp_unexpected got d=%h l=%b id=%h expected no flit",
                                 rs_tdata, rs_tlast, rs_tid);
                    end else begin
                        e = exp_q.pop_front();
                        if (rs_tdata !== e.data || rs_tlast !== e.last || rs_tid !== e.tid ||
                            rs_tstrb !== 4'hF) begin
                            $display("FAIL resp_flit got d=%h l=%b id=%h s=%h expected d=%h l=%b id=%h s=f",
                                     rs_tdata, rs_tlast, rs_tid, rs_tstrb, e.data, e.last, e.tid);
                        end else n_pass++;
                    end
                end else begin
                    stall_q = 1'b1;
                    s_data  = rs_tdata;
                    s_last  = rs_tlast;
                    s_tid   = rs_tid;
                end
            end
        end
    end

    // ------------------------------------------------------- response ready
    initial begin
        rs_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rs_tready = toggle ? ~rs_tready : 1'b1;
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l, input logic [3:0] id);
        int n = 0;
        rq_tdata  = d;
        rq_tstrb  = s;
        rq_tlast  = l;
        rq_tid    = id;
        rq_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!rq_tready && n < 100);
        if (!rq_tready) begin
            n_chk++;
            $display("FAIL req_accept_timeout got tready=0 expected tready=1");
        end
        @(posedge clk);
        #1;
        rq_tvalid = 1'b0;
    endtask

    task automatic pkt(input logic op, input logic [1:0] sx, input logic [1:0] sy,
                       input logic [3:0] lm1, input logic [3:0] id, input logic [31:0] addr,
                       input int nb, input logic [3:0] strb);
        send(req_hdr(op, sx, sy, lm1), 4'hF, 1'b0, id);
        send(addr, 4'hF, nb == 0, id);
        for (int i = 0; i < nb; i++) send(wd[i], strb, i == nb - 1, id);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL resp_timeout got %0d flits outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic write_pkt(input logic [3:0] lm1, input logic [3:0] id, input logic [31:0] addr,
                             input int nb, input logic [3:0] strb, input logic err);
        expect_flit(rsp_hdr(2'd1, 2'd2, 1'b1, lm1, err), 1'b1, id);
        pkt(1'b1, 2'd1, 2'd2, lm1, id, addr, nb, strb);
        wait_idle();
    endtask

    // Read response data is listed in wd[] before calling.
    task automatic read_pkt(input logic [3:0] lm1, input logic [3:0] id, input logic [31:0] addr,
                            input logic err);
        expect_flit(rsp_hdr(2'd1, 2'd2, 1'b0, lm1, err), 1'b0, id);
        for (int k = 0; k <= int'(lm1); k++) expect_flit(wd[k], k == int'(lm1), id);
        pkt(1'b0, 2'd1, 2'd2, lm1, id, addr, 0, 4'hF);
        wait_idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        rq_tvalid = 1'b0;
        rq_tdata  = '0;
        rq_tstrb  = '0;
        rq_tlast  = 1'b0;
        rq_tid    = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", 32'(rs_tvalid), 32'd0);
        chk("rst_tready", 32'(rq_tready), 32'd0);
        chk("rst_tlast",  32'(rs_tlast),  32'd0);
        chk("rst_tdata",  rs_tdata,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_tready", 32'(rq_tready), 32'd1);

        // 4-beat write then read back under toggling backpressure
        for (int k = 0; k < 4; k++) wd[k] = 32'hCAFE_00A0 + 32'(k);
        write_pkt(4'd3, 4'd3, 32'h10, 4, 4'hF, 1'b0);
        toggle = 1'b1;
        read_pkt(4'd3, 4'd5, 32'h10, 1'b0);
        toggle = 1'b0;

        // Byte strobes: only bytes 0 and 2 overwritten
        wd[0] = 32'hFFFF_FFFF;
        write_pkt(4'd0, 4'd1, 32'h30, 1, 4'hF, 1'b0);
        wd[0] = 32'h1122_3344;
        write_pkt(4'd0, 4'd2, 32'h30, 1, 4'b0101, 1'b0);
        wd[0] = 32'hFF22_FF44;
        read_pkt(4'd0, 4'd2, 32'h30, 1'b0);

        // Top-of-memory boundary: len 1 at 255 is legal, len 2 is not
        wd[0] = 32'h5555_AAAA;
        write_pkt(4'd0, 4'd4, 32'hFF, 1, 4'hF, 1'b0);
        wd[0] = 32'hBAD0_0000;
        wd[1] = 32'hBAD0_0001;
        write_pkt(4'd1, 4'd6, 32'hFF, 2, 4'hF, 1'b1);
        wd[0] = 32'h0;
        wd[1] = 32'h0;
        read_pkt(4'd1, 4'd7, 32'hFF, 1'b1);
        wd[0] = 32'h5555_AAAA;
        read_pkt(4'd0, 4'd8, 32'hFF, 1'b0);

        // Header-only packet
        expect_flit(rsp_hdr(2'd2, 2'd1, 1'b0, 4'd0, 1'b1), 1'b1, 4'd9);
        send(req_hdr(1'b0, 2'd2, 2'd1, 4'd0), 4'hF, 1'b1, 4'd9);
        wait_idle();

        // Early TLAST: only beats 0..1 land
        for (int k = 0; k < 4; k++) wd[k] = 32'h4040_4040 + 32'(k);
        write_pkt(4'd3, 4'd1, 32'h40, 4, 4'hF, 1'b0);
        wd[0] = 32'hE000_0000;
        wd[1] = 32'hE000_0001;
        write_pkt(4'd3, 4'd2, 32'h40, 2, 4'hF, 1'b1);
        wd[2] = 32'h4040_4042;
        wd[3] = 32'h4040_4043;
        read_pkt(4'd3, 4'd3, 32'h40, 1'b0);

        // Overlong write: len 2 with 5 beats, extra beats drained
        for (int k = 0; k < 4; k++) wd[k] = 32'h5050_5050 + 32'(k);
        write_pkt(4'd3, 4'd4, 32'h50, 4, 4'hF, 1'b0);
        for (int k = 0; k < 5; k++) wd[k] = 32'hF000_0000 + 32'(k);
        write_pkt(4'd1, 4'd5, 32'h50, 5, 4'hF, 1'b1);
        wd[2] = 32'h5050_5052;
        wd[3] = 32'h5050_5053;
        read_pkt(4'd3, 4'd6, 32'h50, 1'b0);

        // Reset in the middle of a write, during beat 2
        send(req_hdr(1'b1, 2'd1, 2'd2, 4'd3), 4'hF, 1'b0, 4'd7);
        send(32'h20, 4'hF, 1'b0, 4'd7);
        send(32'hC000_0000, 4'hF, 1'b0, 4'd7);
        send(32'hC000_0001, 4'hF, 1'b0, 4'd7);
        rq_tdata  = 32'hC000_0002;
        rq_tlast  = 1'b0;
        rq_tvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_tready", 32'(rq_tready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_tvalid", 32'(rs_tvalid), 32'd0);
        rq_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_tready", 32'(rq_tready), 32'd1);
        chk("postrst_tvalid", 32'(rs_tvalid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("postrst_no_resp", 32'(rs_tvalid), 32'd0);
        wd[0] = 32'hC000_0000;
        wd[1] = 32'hC000_0001;
        read_pkt(4'd1, 4'd8, 32'h20, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got still running expected finished");
        $fatal(1, "timeout");
    end

endmodule
